// File: rtl/reg_file_32x32_if.sv
// Bus bundle for the 32x32 register file: two read ports and one write port.
// The master drives addresses and write data; the slave (register file) returns read data.
interface reg_file_32x32_if #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 5
);
  logic [ADDR_SIZE-1:0] rd_addr1_in;
  logic [ADDR_SIZE-1:0] rd_addr2_in;
  logic [WORD_SIZE-1:0] rd_data1_out;
  logic [WORD_SIZE-1:0] rd_data2_out;
  logic                 wr_en_in;
  logic [ADDR_SIZE-1:0] wr_addr_in;
  logic [WORD_SIZE-1:0] wr_data_in;

  modport master (
    output rd_addr1_in, rd_addr2_in, wr_en_in, wr_addr_in, wr_data_in,
    input  rd_data1_out, rd_data2_out
  );

  modport slave (
    input  rd_addr1_in, rd_addr2_in, wr_en_in, wr_addr_in, wr_data_in,
    output rd_data1_out, rd_data2_out
  );
endinterface

// File: rtl/reg_file_32x32.sv
// 2-read / 1-write register file with hardwired-zero r0, combinational reads,
// write-before-read bypass and asynchronous active-low clear.
module reg_file_32x32 #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  reg_file_32x32_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_SIZE;

  logic [WORD_SIZE-1:0] regs [DEPTH];
  logic [ADDR_SIZE-1:0] rd_addr [2];
  logic [WORD_SIZE-1:0] rd_data [2];
  logic                 wr_hit;

  // A write is real only when enabled and not aimed at r0.
  assign wr_hit = bus.wr_en_in && (bus.wr_addr_in != '0);

  assign regs[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_reg
      logic [WORD_SIZE-1:0] q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
        end else if (wr_hit && (bus.wr_addr_in == ADDR_SIZE'(gi))) begin
          q <= bus.wr_data_in;
        end
      end

      assign regs[gi] = q;
    end
  endgenerate

  assign rd_addr[0]       = bus.rd_addr1_in;
  assign rd_addr[1]       = bus.rd_addr2_in;
  assign bus.rd_data1_out = rd_data[0];
  assign bus.rd_data2_out = rd_data[1];

  // Reads return 0 during reset and for r0; otherwise forward pending write data.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [WORD_SIZE-1:0] data;

      always_comb begin
        data = '0;
        if (rst_n && (rd_addr[gi] != '0)) begin
          if (wr_hit && (rd_addr[gi] == bus.wr_addr_in)) begin
            data = bus.wr_data_in;
          end else begin
            data = regs[rd_addr[gi]];
          end
        end
      end

      assign rd_data[gi] = data;
    end
  endgenerate
endmodule

// File: tb/tb_reg_file_32x32.sv
// Self-checking bench: an architectural register model plus a per-cycle compare process,
// backed by hand-computed directed checks.
module tb_reg_file_32x32;
  logic clk = 1'b0;
  logic rst_n;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  logic [31:0] model [32];

  reg_file_32x32_if #(.WORD_SIZE(32), .ADDR_SIZE(5)) bus ();

  reg_file_32x32 #(.WORD_SIZE(32), .ADDR_SIZE(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural state: registers change only on a clock edge outside reset.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && bus.wr_en_in === 1'b1 && bus.wr_addr_in != 5'd0)
      model[bus.wr_addr_in] = bus.wr_data_in;
  end

  always @(negedge rst_n) begin
    for (int k = 0; k < 32; k++) model[k] = 32'h0;
  end

  function automatic logic [31:0] expect_read(input logic [4:0] a);
    if (rst_n !== 1'b1) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (bus.wr_en_in === 1'b1 && bus.wr_addr_in == a) return bus.wr_data_in;
    return model[a];
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_rd1", bus.rd_data1_out, expect_read(bus.rd_addr1_in));
      check("cyc_rd2", bus.rd_data2_out, expect_read(bus.rd_addr2_in));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra1, input logic [4:0] ra2);
    bus.wr_en_in    = we;
    bus.wr_addr_in  = wa;
    bus.wr_data_in  = wd;
    bus.rd_addr1_in = ra1;
    bus.rd_addr2_in = ra2;
  endtask

  task automatic write_reg(input logic [4:0] wa, input logic [31:0] wd);
    set_bus(1'b1, wa, wd, 5'd0, 5'd0);
    $display("[TB] write r%0d = %h", wa, wd);
    step();
    bus.wr_en_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 32; k++) model[k] = 32'h0;
    rst_n = 1'b0;
    set_bus(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
    #1;
    check("reset_rd1", bus.rd_data1_out, 32'h0);
    check("reset_rd2", bus.rd_data2_out, 32'h0);
    step();
    step();
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    step();

    // Write then read on both ports
    write_reg(5'd7, 32'h12345678);
    set_bus(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    #2;
    check("r7_rd1", bus.rd_data1_out, 32'h12345678);
    check("r7_rd2", bus.rd_data2_out, 32'h12345678);
    $display("[TB] read r7 on both ports");

    // r0 write discarded, no bypass
    set_bus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    #2;
    check("r0_during", bus.rd_data1_out, 32'h0);
    step();
    bus.wr_en_in = 1'b0;
    #2;
    check("r0_after", bus.rd_data1_out, 32'h0);
    $display("[TB] write r0 discarded");

    // Bypass
    write_reg(5'd3, 32'h00000001);
    set_bus(1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3);
    #2;
    check("bypass_rd2", bus.rd_data2_out, 32'hA5A5A5A5);
    check("bypass_rd1", bus.rd_data1_out, 32'hA5A5A5A5);
    step();
    bus.wr_en_in = 1'b0;
    #2;
    check("r3_after", bus.rd_data2_out, 32'hA5A5A5A5);
    $display("[TB] bypass r3");

    // Enable off, including X data
    write_reg(5'd9, 32'h00000055);
    set_bus(1'b0, 5'd9, 32'hCAFEF00D, 5'd9, 5'd9);
    step();
    #2;
    check("en_off_r9", bus.rd_data1_out, 32'h00000055);
    bus.wr_data_in = 'x;
    step();
    #2;
    check("x_data_r9", bus.rd_data2_out, 32'h00000055);
    bus.wr_data_in = 32'h0;
    $display("[TB] enable-off hold r9");

    // Asynchronous reset between edges, then a write held across reset release
    write_reg(5'd5, 32'hDEADBEEF);
    set_bus(1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
    #2;
    check("r5_loaded", bus.rd_data1_out, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    check("async_clr_r5", bus.rd_data1_out, 32'h0);
    check("async_clr_r7", bus.rd_data2_out, 32'h0);
    set_bus(1'b1, 5'd5, 32'h00001234, 5'd5, 5'd7);
    step();
    #2;
    check("rst_blocks_wr", bus.rd_data1_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_r7", bus.rd_data2_out, 32'h0);
    step();
    bus.wr_en_in = 1'b0;
    #2;
    check("first_wr_after_rst", bus.rd_data1_out, 32'h00001234);
    $display("[TB] async reset and release");

    // Short mixed traffic, checked per cycle by the compare process
    for (int n = 0; n < 40; n++) begin
      set_bus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      step();
    end

    // Full sweep
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i) * 32'h01010101);
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) begin
        set_bus(1'b0, 5'd0, 32'h0, 5'(i), 5'(j));
        @(negedge clk);
        check("sweep_rd1", bus.rd_data1_out, 32'(i) * 32'h01010101);
        check("sweep_rd2", bus.rd_data2_out, 32'(j) * 32'h01010101);
      end
    end
    $display("[TB] sweep done");

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reg_file_32x32.md
REG_FILE_32X32 -- requirements
Module: reg_file_32x32

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 32, data width of each register and data port.
REQ-002 The block SHALL have parameter ADDR_SIZE, default 5, register address width; depth = 2**ADDR_SIZE = 32.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 The block SHALL have port rd_addr1_in, input, ADDR_SIZE, read port 1 address (rs).
REQ-006 The block SHALL have port rd_addr2_in, input, ADDR_SIZE, read port 2 address (rt).
REQ-007 The block SHALL have port rd_data1_out, output, WORD_SIZE, read port 1 data.
REQ-008 The block SHALL have port rd_data2_out, output, WORD_SIZE, read port 2 data.
REQ-009 The block SHALL have port wr_en_in, input, 1, write enable (RegWrite).
REQ-010 The block SHALL have port wr_addr_in, input, ADDR_SIZE, destination register; driven by the 5-bit rt/rd destination-select mux.
REQ-011 The block SHALL have port wr_data_in, input, WORD_SIZE, write-back data.

Function
REQ-012 Storage SHALL be 32 registers of WORD_SIZE bits, r0..r31.
REQ-013 Write: at a rising clk edge with wr_en_in=1 and wr_addr_in!=0, r[wr_addr_in] SHALL take wr_data_in; write latency is 1 edge.
REQ-014 wr_en_in=0 SHALL leave all registers unchanged, regardless of wr_addr_in/wr_data_in.
REQ-015 r0 SHALL read as 0 always; writes to address 0 SHALL be discarded with no other side effect.
REQ-016 Reads SHALL be combinational: rd_dataN_out = r[rd_addrN_in] within the same cycle; no clocked read latency.
REQ-017 Bypass: when wr_en_in=1, wr_addr_in!=0 and rd_addrN_in==wr_addr_in, rd_dataN_out SHALL equal wr_data_in in that cycle (write-before-read).
REQ-018 Both read ports SHALL be independent; identical read addresses SHALL return identical data, including under bypass.
REQ-019 Address 0 on a read port SHALL return 0 even if wr_addr_in=0 with wr_en_in=1 (no bypass for r0).
REQ-020 Addresses SHALL be full-range; no out-of-range case exists for ADDR_SIZE=5.
REQ-021 X/Z on wr_data_in SHALL NOT corrupt any register when wr_en_in=0.

Reset
REQ-022 rst_n=0 SHALL asynchronously clear r1..r31 to 0, without waiting for a clk edge.
REQ-023 While rst_n=0, writes SHALL be ignored; rd_data1_out/rd_data2_out SHALL read 0 for every address.
REQ-024 Reset asserted mid-operation SHALL override a same-cycle write; deassertion SHALL be sampled so the first write occurs on the first rising edge after rst_n rises.

Verification
REQ-025 Reset: pre-load r5=0xDEADBEEF, pulse rst_n low between edges -> rd_data1_out with rd_addr1_in=5 reads 0x00000000 immediately, before next clk.
REQ-026 Write/read: write r7=0x12345678, next cycle rd_addr1_in=7, rd_addr2_in=7 -> both outputs 0x12345678.
REQ-027 r0: wr_en_in=1, wr_addr_in=0, wr_data_in=0xFFFFFFFF -> rd_data1_out with rd_addr1_in=0 reads 0 during and after the edge.
REQ-028 Bypass: r3=0x1; same cycle wr_en_in=1, wr_addr_in=3, wr_data_in=0xA5A5A5A5, rd_addr2_in=3 -> rd_data2_out=0xA5A5A5A5 before the edge; r3=0xA5A5A5A5 after.
REQ-029 Enable off: wr_en_in=0, wr_addr_in=9, wr_data_in=0xCAFEF00D with r9=0x55 -> r9 still 0x55 after edge.
REQ-030 Sweep: write r[i]=i*0x01010101 for i=1..31, read back all pairs on both ports -> every value matches; r0=0.
